// File: rtl/ncl_pkg.sv
// Dual-rail NCL encoding, pair predicates, clocked TH22 rule and the one-bit
// dual-rail full-adder cell used by every pipeline stage.
package ncl_pkg;

  typedef struct packed {
    logic r1;
    logic r0;
  } dr_t;

  typedef struct packed {
    dr_t s;
    dr_t co;
  } grp_t;

  localparam dr_t DR_NULL = 2'b00;
  localparam dr_t DR_0    = 2'b01;
  localparam dr_t DR_1    = 2'b10;

  function automatic logic is_data(input dr_t p);
    return p.r1 ^ p.r0;
  endfunction

  function automatic logic is_null(input dr_t p);
    return ~(p.r1 | p.r0);
  endfunction

  function automatic logic is_illegal(input dr_t p);
    return p.r1 & p.r0;
  endfunction

  function automatic dr_t dr_enc(input logic b);
    return b ? DR_1 : DR_0;
  endfunction

  function automatic logic th22_next(input logic in, input logic q, input logic en);
    return (in & en) | (q & (in | en));
  endfunction

  // Carry resolves as soon as two inputs agree; sum waits for all three.
  function automatic grp_t add_grp(input dr_t a, input dr_t b, input dr_t c);
    grp_t r;
    logic all_data;
    logic par;
    all_data = is_data(a) & is_data(b) & is_data(c);
    par      = a.r1 ^ b.r1 ^ c.r1;
    r.co.r1  = (a.r1 & b.r1) | (a.r1 & c.r1) | (b.r1 & c.r1);
    r.co.r0  = (a.r0 & b.r0) | (a.r0 & c.r0) | (b.r0 & c.r0);
    r.s.r1   = all_data & par;
    r.s.r0   = all_data & ~par;
    return r;
  endfunction

endpackage

// File: rtl/ncl_dr_stage.sv
// One pipeline stage: a bank of per-rail clocked TH22 registers plus a
// registered completion flag with hysteresis (sets on all-DATA, clears on all-NULL).
module ncl_dr_stage
  import ncl_pkg::*;
#(
  parameter int NPAIR = 1
) (
  input  logic             clk,
  input  logic             init,
  input  logic             en,
  input  logic [NPAIR-1:0] d_r1,
  input  logic [NPAIR-1:0] d_r0,
  output logic [NPAIR-1:0] q_r1,
  output logic [NPAIR-1:0] q_r0,
  output logic             comp
);

  logic [NPAIR-1:0] r1_q, r1_d;
  logic [NPAIR-1:0] r0_q, r0_d;
  logic             comp_q, comp_d;

  always_comb begin
    r1_d   = '0;
    r0_d   = '0;
    for (int i = 0; i < NPAIR; i++) begin
      r1_d[i] = th22_next(d_r1[i], r1_q[i], en);
      r0_d[i] = th22_next(d_r0[i], r0_q[i], en);
    end
    comp_d = comp_q;
    if (&(r1_d ^ r0_d)) begin
      comp_d = 1'b1;
    end else if (~|(r1_d | r0_d)) begin
      comp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r1_q   <= '0;
      r0_q   <= '0;
      comp_q <= 1'b0;
    end else begin
      r1_q   <= r1_d;
      r0_q   <= r0_d;
      comp_q <= comp_d;
    end
  end

  assign q_r1 = r1_q;
  assign q_r0 = r0_q;
  assign comp = comp_q;

endmodule

// File: rtl/ncl_adder_2d_pipe.sv
// 2D-pipelined dual-rail NCL ripple adder: stage k adds bit group k and
// passes already-summed bits, the carry and not-yet-used B bits onward.
module ncl_adder_2d_pipe
  import ncl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] a_r1,
  input  logic [WIDTH-1:0] a_r0,
  input  logic [WIDTH-1:0] b_r1,
  input  logic [WIDTH-1:0] b_r0,
  input  logic             cin_r1,
  input  logic             cin_r0,
  output logic             in_comp,
  output logic [WIDTH-1:0] s_r1,
  output logic [WIDTH-1:0] s_r0,
  output logic             co_r1,
  output logic             co_r0,
  input  logic             out_comp,
  output logic             err
);

  localparam int NSTG = WIDTH / BPS;

  // Stage k holds WIDTH sum/A pairs, one carry pair and the B pairs above
  // its group; this gives the offset of stage k in the flat register vector.
  function automatic int stg_off(input int k);
    return k * (2 * WIDTH + 1) - (BPS * k * (k + 1)) / 2;
  endfunction

  localparam int TOT  = stg_off(NSTG);
  localparam int LOFF = stg_off(NSTG - 1);

  wire [TOT-1:0]  q_r1;
  wire [TOT-1:0]  q_r0;
  wire [NSTG-1:0] comp_v;

  logic err_q, err_d;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    localparam int LO  = gi * BPS;
    localparam int HI  = LO + BPS;
    localparam int NP  = 2 * WIDTH + 1 - HI;
    localparam int OFF = stg_off(gi);

    logic [WIDTH-1:0]    in_sa_r1, in_sa_r0;
    logic [WIDTH-1:0]    out_sa_r1, out_sa_r0;
    logic [WIDTH-LO-1:0] in_b_r1, in_b_r0;
    logic                in_c_r1, in_c_r0;
    logic                en;
    logic [NP-1:0]       d_r1, d_r0;
    dr_t                 cy  [BPS+1];
    grp_t                grp [BPS];

    if (gi == 0) begin : g_in
      assign in_sa_r1 = a_r1;
      assign in_sa_r0 = a_r0;
      assign in_b_r1  = b_r1;
      assign in_b_r0  = b_r0;
      assign in_c_r1  = cin_r1;
      assign in_c_r0  = cin_r0;
    end else begin : g_in
      localparam int POFF = stg_off(gi - 1);
      assign in_sa_r1 = q_r1[POFF +: WIDTH];
      assign in_sa_r0 = q_r0[POFF +: WIDTH];
      assign in_c_r1  = q_r1[POFF + WIDTH];
      assign in_c_r0  = q_r0[POFF + WIDTH];
      assign in_b_r1  = q_r1[POFF + WIDTH + 1 +: WIDTH - LO];
      assign in_b_r0  = q_r0[POFF + WIDTH + 1 +: WIDTH - LO];
    end

    assign cy[0] = {in_c_r1, in_c_r0};
    for (genvar gj = 0; gj < BPS; gj++) begin : g_bit
      assign grp[gj]  = add_grp({in_sa_r1[LO+gj], in_sa_r0[LO+gj]},
                                {in_b_r1[gj], in_b_r0[gj]}, cy[gj]);
      assign cy[gj+1] = grp[gj].co;
    end

    always_comb begin
      out_sa_r1 = in_sa_r1;
      out_sa_r0 = in_sa_r0;
      for (int j = 0; j < BPS; j++) begin
        out_sa_r1[LO+j] = grp[j].s.r1;
        out_sa_r0[LO+j] = grp[j].s.r0;
      end
    end

    if (HI < WIDTH) begin : g_pack
      assign d_r1 = {in_b_r1[WIDTH-LO-1:BPS], cy[BPS].r1, out_sa_r1};
      assign d_r0 = {in_b_r0[WIDTH-LO-1:BPS], cy[BPS].r0, out_sa_r0};
    end else begin : g_pack
      assign d_r1 = {cy[BPS].r1, out_sa_r1};
      assign d_r0 = {cy[BPS].r0, out_sa_r0};
    end

    if (gi == NSTG - 1) begin : g_en
      assign en = ~out_comp;
    end else begin : g_en
      assign en = ~comp_v[gi+1];
    end

    ncl_dr_stage #(.NPAIR(NP)) u_stage (
      .clk  (clk),
      .init (init),
      .en   (en),
      .d_r1 (d_r1),
      .d_r0 (d_r0),
      .q_r1 (q_r1[OFF +: NP]),
      .q_r0 (q_r0[OFF +: NP]),
      .comp (comp_v[gi])
    );
  end

  always_comb begin
    err_d = err_q | (|(a_r1 & a_r0)) | (|(b_r1 & b_r0)) | (cin_r1 & cin_r0);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err     = err_q;
  assign in_comp = comp_v[0];
  assign s_r1    = q_r1[LOFF +: WIDTH];
  assign s_r0    = q_r0[LOFF +: WIDTH];
  assign co_r1   = q_r1[LOFF + WIDTH];
  assign co_r0   = q_r0[LOFF + WIDTH];

endmodule

// File: tb/tb_ncl_adder_2d_pipe.sv
// Directed bench for the 8-bit, 1-bit-per-stage NCL adder pipeline:
// reset, latency, ripple, partial input, backpressure, throughput, illegal input and init.
module tb_ncl_adder_2d_pipe;

  logic       clk = 1'b0;
  logic       init;
  logic [7:0] a_r1, a_r0, b_r1, b_r0;
  logic       cin_r1, cin_r0;
  logic       in_comp;
  logic [7:0] s_r1, s_r0;
  logic       co_r1, co_r0;
  logic       out_comp;
  logic       err;

  logic hold_bp, auto_sink, manual_oc;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] tx_a [16];
  logic [7:0] tx_b [16];
  logic       tx_c [16];
  logic [8:0] tx_e [16];
  int         tx_n, tx_i;
  bit         drv_data;
  logic [8:0] rx_v   [16];
  int         rx_cyc [16];
  int         rx_n, cyc;
  bit         prev_data;

  wire out_all_data = (&(s_r1 ^ s_r0)) & (co_r1 ^ co_r0);
  assign out_comp = hold_bp | (auto_sink ? out_all_data : manual_oc);

  always #5 clk = ~clk;

  ncl_adder_2d_pipe #(.WIDTH(8), .BPS(1)) dut (
    .clk      (clk),
    .init     (init),
    .a_r1     (a_r1),
    .a_r0     (a_r0),
    .b_r1     (b_r1),
    .b_r0     (b_r0),
    .cin_r1   (cin_r1),
    .cin_r0   (cin_r0),
    .in_comp  (in_comp),
    .s_r1     (s_r1),
    .s_r0     (s_r0),
    .co_r1    (co_r1),
    .co_r0    (co_r0),
    .out_comp (out_comp),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic drive_tok(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_r1 = a;  a_r0 = ~a;
    b_r1 = b;  b_r0 = ~b;
    cin_r1 = c; cin_r0 = ~c;
  endtask

  task automatic drive_null();
    a_r1 = '0; a_r0 = '0; b_r1 = '0; b_r0 = '0; cin_r1 = 1'b0; cin_r0 = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    drive_null();
    step(1);
    init = 1'b0;
  endtask

  task automatic env_reset(input int n);
    tx_n = n; tx_i = 0; drv_data = 1'b0;
    rx_n = 0; prev_data = 1'b0; cyc = 0;
    drive_null();
  endtask

  // One clock of a four-phase source and a sink recorder.
  task automatic env_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (out_all_data && !prev_data && rx_n < 16) begin
      rx_v[rx_n]   = {co_r1, s_r1};
      rx_cyc[rx_n] = cyc;
      $display("rx token %0d = %03h at cycle %0d", rx_n, {co_r1, s_r1}, cyc);
      rx_n++;
    end
    prev_data = out_all_data;
    if (drv_data) begin
      if (in_comp) begin
        drive_null();
        drv_data = 1'b0;
      end
    end else if (!in_comp && tx_i < tx_n) begin
      drive_tok(tx_a[tx_i], tx_b[tx_i], tx_c[tx_i]);
      tx_i++;
      drv_data = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_bp = 1'b0; auto_sink = 1'b0; manual_oc = 1'b0;
    drive_null();

    // Reset
    init = 1'b1;
    step(1);
    init = 1'b0;
    chk("rst_out", {14'd0, co_r1, co_r0, s_r1, s_r0}, 32'd0);
    chk("rst_in_comp", {31'd0, in_comp}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    $display("reset: out=%05h in_comp=%0d err=%0d", {co_r1, co_r0, s_r1, s_r0}, in_comp, err);

    // 0x5A + 0x3C = 0x096
    drive_tok(8'h5A, 8'h3C, 1'b0);
    step(1);
    chk("lat_in_comp", {31'd0, in_comp}, 32'd1);
    step(6);
    chk("lat_null_at7", {14'd0, co_r1, co_r0, s_r1, s_r0}, 32'd0);
    step(1);
    chk("lat_sum", {14'd0, co_r1, co_r0, s_r1, s_r0}, {14'd0, 1'b0, 1'b1, 8'h96, 8'h69});
    $display("5A+3C: s=%02h co=%0d", s_r1, co_r1);

    // Full ripple: 0xFF + 0x01 = 0x100
    do_init();
    drive_tok(8'hFF, 8'h01, 1'b0);
    step(8);
    chk("ripple1", {14'd0, co_r1, co_r0, s_r1, s_r0}, {14'd0, 1'b1, 1'b0, 8'h00, 8'hFF});
    $display("FF+01: s=%02h co=%0d", s_r1, co_r1);

    // 0xFF + 0xFF + 1 = 0x1FF
    do_init();
    drive_tok(8'hFF, 8'hFF, 1'b1);
    step(8);
    chk("ripple2", {14'd0, co_r1, co_r0, s_r1, s_r0}, {14'd0, 1'b1, 1'b0, 8'hFF, 8'h00});
    $display("FF+FF+1: s=%02h co=%0d", s_r1, co_r1);

    // Partial input leaves in_comp low until every pair is DATA
    do_init();
    a_r1 = 8'h0F; a_r0 = 8'hF0;
    step(2);
    chk("partial_in_comp", {31'd0, in_comp}, 32'd0);
    b_r1 = 8'h01; b_r0 = 8'hFE; cin_r1 = 1'b0; cin_r0 = 1'b1;
    step(1);
    chk("complete_in_comp", {31'd0, in_comp}, 32'd1);
    $display("partial then complete: in_comp=%0d", in_comp);

    // Backpressure
    do_init();
    auto_sink = 1'b1;
    tx_a[0] = 8'h12; tx_b[0] = 8'h34; tx_c[0] = 1'b0;
    tx_a[1] = 8'h80; tx_b[1] = 8'h80; tx_c[1] = 1'b1;
    tx_a[2] = 8'hF0; tx_b[2] = 8'h0F; tx_c[2] = 1'b1;
    env_reset(3);
    for (int k = 0; k < 40 && rx_n < 1; k++) env_cycle();
    chk("bp_first_arrived", rx_n, 1);
    hold_bp = 1'b1;
    repeat (40) env_cycle();
    chk("bp_stalled_count", rx_n, 1);
    chk("bp_tok1", {23'd0, rx_v[0]}, 32'h046);
    hold_bp = 1'b0;
    for (int k = 0; k < 80 && rx_n < 3; k++) env_cycle();
    chk("bp_release_count", rx_n, 3);
    chk("bp_tok2", {23'd0, rx_v[1]}, 32'h101);
    chk("bp_tok3", {23'd0, rx_v[2]}, 32'h100);

    // Throughput with a same-cycle sink
    do_init();
    for (int i = 0; i < 10; i++) begin
      tx_a[i] = 8'($urandom_range(0, 255));
      tx_b[i] = 8'($urandom_range(0, 255));
      tx_c[i] = 1'($urandom_range(0, 1));
      tx_e[i] = 9'(tx_a[i]) + 9'(tx_b[i]) + 9'(tx_c[i]);
    end
    env_reset(10);
    for (int k = 0; k < 100 && rx_n < 10; k++) env_cycle();
    chk("tput_count", rx_n, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tput_val%0d", i), {23'd0, rx_v[i]}, {23'd0, tx_e[i]});
      if (i > 0) chk($sformatf("tput_gap%0d", i), rx_cyc[i] - rx_cyc[i-1], 4);
    end

    // Illegal pair and init mid-flight
    auto_sink = 1'b0; manual_oc = 1'b0;
    do_init();
    a_r1 = 8'h0D; a_r0 = 8'hFA;
    b_r1 = 8'h00; b_r0 = 8'hFF; cin_r1 = 1'b0; cin_r0 = 1'b1;
    step(1);
    chk("illegal_err", {31'd0, err}, 32'd1);
    drive_tok(8'h11, 8'h22, 1'b0);
    step(4);
    chk("err_sticky", {31'd0, err}, 32'd1);
    $display("illegal: err=%0d", err);
    init = 1'b1;
    step(1);
    init = 1'b0;
    drive_null();
    chk("init_out_null", {14'd0, co_r1, co_r0, s_r1, s_r0}, 32'd0);
    chk("init_in_comp", {31'd0, in_comp}, 32'd0);
    chk("init_err", {31'd0, err}, 32'd0);
    step(10);
    chk("init_no_partial", {14'd0, co_r1, co_r0, s_r1, s_r0}, 32'd0);
    $display("after init: out=%05h err=%0d", {co_r1, co_r0, s_r1, s_r0}, err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
